// File: rtl/approx_mul_seq.sv
// Shift-add multiplier with optional approximate mode that skips the DROP low multiplier bits.
// Latency WIDTH (exact) or WIDTH-DROP (approx) cycles after accept; result held in DONE until out_ready.
module approx_mul_seq #(
  parameter int WIDTH = 4,
  parameter int DROP  = 1,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               approx,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               out_approx,
  output logic [CNT_W-1:0]   approx_count
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);
  localparam logic [IW-1:0] DROP_IDX = IW'(DROP);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_approx;
  logic [2*WIDTH-1:0] r_acc;
  logic [IW-1:0]      r_idx;
  logic [2*WIDTH-1:0] r_product;
  logic               r_out_approx;
  logic [CNT_W-1:0]   r_count;

  logic [2*WIDTH-1:0] w_addend;
  logic [2*WIDTH-1:0] w_sum;
  logic               w_accept;

  assign w_accept = in_valid && (r_state == S_IDLE);
  assign w_addend = r_b[r_idx] ? ({{WIDTH{1'b0}}, r_a} << r_idx) : '0;
  assign w_sum    = r_acc + w_addend;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_approx     <= 1'b0;
      r_acc        <= '0;
      r_idx        <= '0;
      r_product    <= '0;
      r_out_approx <= 1'b0;
      r_count      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a      <= a;
            r_b      <= b;
            r_approx <= approx;
            r_acc    <= '0;
            r_idx    <= approx ? DROP_IDX : '0;
            r_state  <= S_BUSY;
            // Saturate rather than wrap so a long-running count never reads low.
            if (approx && !(&r_count)) begin
              r_count <= r_count + 1'b1;
            end
          end
        end
        S_BUSY: begin
          r_acc <= w_sum;
          r_idx <= r_idx + 1'b1;
          if (r_idx == LAST_IDX) begin
            r_product    <= w_sum;
            r_out_approx <= r_approx;
            r_state      <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready     = (r_state == S_IDLE);
  assign out_valid    = (r_state == S_DONE);
  assign product      = r_product;
  assign out_approx   = r_out_approx;
  assign approx_count = r_count;

endmodule

// File: tb/tb_approx_mul_seq.sv
// Directed bench for approx_mul_seq (WIDTH=4, DROP=1, CNT_W=2) with immediate-assertion checks.
module tb_approx_mul_seq;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic       approx;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] product;
  logic       out_approx;
  logic [1:0] approx_count;

  int total;
  int bad;

  approx_mul_seq #(.WIDTH(4), .DROP(1), .CNT_W(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .a            (a),
    .b            (b),
    .approx       (approx),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .product      (product),
    .out_approx   (out_approx),
    .approx_count (approx_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one operation, measure cycles to out_valid, check result, then complete the handshake.
  task automatic run_op(input string tag, input logic [3:0] ta, input logic [3:0] tb,
                        input logic tm, input int exp_lat, input logic [7:0] exp_prod,
                        input logic [1:0] exp_cnt);
    int cyc;
    check({tag, "_rdy"}, {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1;
    a        = ta;
    b        = tb;
    approx   = tm;
    step();
    in_valid = 1'b0;
    a        = 4'hx;
    b        = 4'hx;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      step();
      cyc++;
    end
    check({tag, "_lat"}, cyc, exp_lat);
    check({tag, "_prod"}, {24'b0, product}, {24'b0, exp_prod});
    check({tag, "_mode"}, {31'b0, out_approx}, {31'b0, tm});
    check({tag, "_cnt"}, {30'b0, approx_count}, {30'b0, exp_cnt});
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_idle"}, {30'b0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    int cyc;
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = 4'd0;
    b         = 4'd0;
    approx    = 1'b0;
    step();
    step();
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_product", {24'b0, product}, 32'd0);
    check("rst_out_approx", {31'b0, out_approx}, 32'd0);
    check("rst_count", {30'b0, approx_count}, 32'd0);
    rst_n = 1'b1;
    step();

    run_op("exact_13x11", 4'd13, 4'd11, 1'b0, 4, 8'd143, 2'd0);
    run_op("approx_13x11", 4'd13, 4'd11, 1'b1, 3, 8'd130, 2'd1);
    run_op("exact_15x15", 4'd15, 4'd15, 1'b0, 4, 8'd225, 2'd1);
    run_op("approx_15x15", 4'd15, 4'd15, 1'b1, 3, 8'd210, 2'd2);
    run_op("exact_0x9", 4'd0, 4'd9, 1'b0, 4, 8'd0, 2'd2);
    run_op("approx_9x1", 4'd9, 4'd1, 1'b1, 3, 8'd0, 2'd3);

    // Backpressure: 6*7 exact = 42, held while consumer stalls and new requests arrive.
    in_valid = 1'b1;
    a        = 4'd6;
    b        = 4'd7;
    approx   = 1'b0;
    step();
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      step();
      cyc++;
    end
    check("bp_lat", cyc, 4);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      a        = 4'(i + 3);
      b        = 4'(15 - i);
      approx   = ~i[0];
      step();
      check("bp_out_valid", {31'b0, out_valid}, 32'd1);
      check("bp_product", {24'b0, product}, 32'd42);
      check("bp_out_approx", {31'b0, out_approx}, 32'd0);
      check("bp_in_ready", {31'b0, in_ready}, 32'd0);
    end
    // Handshake with a new request already present: 3*5 exact = 15.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a         = 4'd3;
    b         = 4'd5;
    approx    = 1'b0;
    step();
    out_ready = 1'b0;
    check("hs_in_ready", {31'b0, in_ready}, 32'd1);
    check("hs_out_valid", {31'b0, out_valid}, 32'd0);
    check("hs_product_held", {24'b0, product}, 32'd42);
    step();
    in_valid = 1'b0;
    check("hs_next_accept", {31'b0, in_ready}, 32'd0);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      step();
      cyc++;
    end
    check("hs2_lat", cyc, 4);
    check("hs2_product", {24'b0, product}, 32'd15);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Reset during the second BUSY cycle; in_valid high across the reset edge must not be accepted.
    in_valid = 1'b1;
    a        = 4'd13;
    b        = 4'd11;
    approx   = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst_n    = 1'b0;
    in_valid = 1'b1;
    step();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    check("abort_in_ready", {31'b0, in_ready}, 32'd1);
    check("abort_out_valid", {31'b0, out_valid}, 32'd0);
    check("abort_product", {24'b0, product}, 32'd0);
    check("abort_count", {30'b0, approx_count}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      check("abort_no_result", {30'b0, out_valid, in_ready}, 32'd1);
    end

    // Counter saturation at 3 with an interleaved exact operation.
    run_op("sat1", 4'd2, 4'd3, 1'b1, 3, 8'd4, 2'd1);
    run_op("sat2", 4'd7, 4'd6, 1'b1, 3, 8'd42, 2'd2);
    run_op("sat_exact", 4'd5, 4'd5, 1'b0, 4, 8'd25, 2'd2);
    run_op("sat3", 4'd4, 4'd5, 1'b1, 3, 8'd16, 2'd3);
    run_op("sat4", 4'd15, 4'd14, 1'b1, 3, 8'd210, 2'd3);
    run_op("sat5", 4'd1, 4'd1, 1'b1, 3, 8'd0, 2'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/approx_mul_seq.md
APPROX_MUL_SEQ -- requirements
Module: approx_mul_seq

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, meaning operand width in bits (legal range 2..16).
REQ-002 SHALL provide parameter DROP, default 1, meaning the number of least-significant multiplier bits skipped in approximate mode (legal range 0..WIDTH-1).
REQ-003 SHALL provide parameter CNT_W, default 16, meaning the width of the approximate-operation counter.
REQ-004 SHALL have port clk  input  1  the single clock; all state changes on the rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port in_valid  input  1  operand request.
REQ-007 SHALL have port in_ready  output  1  block can accept operands.
REQ-008 SHALL have port a  input  WIDTH  multiplicand, unsigned.
REQ-009 SHALL have port b  input  WIDTH  multiplier, unsigned.
REQ-010 SHALL have port approx  input  1  mode select; 1 = approximate, 0 = exact.
REQ-011 SHALL have port out_valid  output  1  result available.
REQ-012 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-013 SHALL have port product  output  2*WIDTH  unsigned result.
REQ-014 SHALL have port out_approx  output  1  mode with which the current product was computed.
REQ-015 SHALL have port approx_count  output  CNT_W  number of accepted approximate operations, saturating.

Function
REQ-016 SHALL implement a three-state FSM with states IDLE, BUSY and DONE.
REQ-017 SHALL drive in_ready=1 only in IDLE, and out_valid=1 only in DONE.
REQ-018 SHALL accept operands when in_valid and in_ready are both high: latch a, b and approx, clear the accumulator, set the bit index to DROP if approx=1 or to 0 otherwise, and enter BUSY.
REQ-019 SHALL, in each BUSY cycle, add (a << i) to the 2*WIDTH-bit accumulator when b[i]=1, then increment i; no overflow is possible.
REQ-020 SHALL leave BUSY for DONE after processing bit index WIDTH-1, so that out_valid rises exactly N cycles after the accept edge: N=WIDTH when exact, N=WIDTH-DROP when approximate.
REQ-021 SHALL produce the exact result a*b in exact mode.
REQ-022 SHALL produce a*(b with bits [DROP-1:0] forced to 0) in approximate mode; with DROP=0 both modes are identical in result and latency.
REQ-023 SHALL load product and out_approx only on the BUSY->DONE transition, and hold them stable until the next completion, including after the output handshake.
REQ-024 SHALL hold out_valid, product and out_approx in DONE while out_ready=0; on out_valid and out_ready it SHALL return to IDLE on the next edge.
REQ-025 SHALL ignore in_valid, a, b and approx while in BUSY or DONE; there are no overlapping operations, and the earliest new accept is the cycle after the output handshake.
REQ-026 SHALL NOT terminate early on zero operands; latency depends only on the latched mode.
REQ-027 SHALL increment approx_count by 1 on each accepted approximate operation, and SHALL hold it at 2^CNT_W-1 once saturated (no wrap).
REQ-028 SHALL leave approx_count unchanged on exact operations.

Reset
REQ-029 SHALL, while rst_n=0 at a rising edge, force state=IDLE, accumulator=0, bit index=0, product=0, out_approx=0, out_valid=0 and approx_count=0, with in_ready=1 after reset.
REQ-030 SHALL abort any BUSY or DONE operation on reset mid-operation without producing out_valid; the aborted result is discarded.
REQ-031 SHALL NOT accept in_valid in the same cycle that rst_n=0.

Verification
REQ-032 Exact mode, WIDTH=4, DROP=1: a=13, b=11, approx=0 -> out_valid 4 cycles after accept, product=143, out_approx=0, approx_count=0.
REQ-033 Approximate mode: a=13, b=11, approx=1 -> out_valid 3 cycles after accept, product=130, out_approx=1, approx_count=1.
REQ-034 Boundaries: a=15, b=15, exact -> 225; approximate -> 210. a=0, b=9, exact -> 0 after the full 4 cycles. a=9, b=1, approximate -> 0.
REQ-035 Backpressure: out_ready=0 for 5 cycles, with in_valid pulsing and new operands applied -> out_valid stays 1, product stays unchanged, in_ready=0; after the handshake the next accept occurs one cycle later.
REQ-036 Reset: rst_n=0 during the 2nd BUSY cycle -> next cycle IDLE, out_valid=0, product=0, approx_count=0, and no result is emitted.
REQ-037 Saturation with CNT_W=2: five approximate operations -> approx_count reads 1, 2, 3, 3, 3; an interleaved exact operation leaves it unchanged.
